// File: rtl/fifo_pkg.sv
// Shared widths, types and parity helper for the FIFO read-side datapath.
package fifo_pkg;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned PARITY_W = 1;

  typedef logic [NIBBLE_W-1:0] nibble_t;
  typedef logic [BYTE_W-1:0]   byte_t;

  typedef struct packed {
    logic [PARITY_W-1:0] par;
    nibble_t             data;
  } nib_par_t;

  // 1 when nibble plus parity lane carry an odd number of ones (even-parity violation).
  function automatic logic even_par(input nibble_t nibble, input logic [PARITY_W-1:0] par);
    return ^{par, nibble};
  endfunction
endpackage

// File: rtl/nibble_capture_reg.sv
// Holds the first nibble of a pair (with its parity lane) and the lo_valid flag.
module nibble_capture_reg
  import fifo_pkg::*;
(
  input  logic     Clock,
  input  logic     Sclr,
  input  logic     load,
  input  logic     clear,
  input  nib_par_t d,
  output nib_par_t q,
  output logic     lo_valid
);
  always_ff @(posedge Clock) begin
    if (Sclr) begin
      q        <= '0;
      lo_valid <= 1'b0;
    end else if (load) begin
      q        <= d;
      lo_valid <= 1'b1;
    end else if (clear) begin
      lo_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fifo_nibble_packer.sv
// Drains a showahead-off 4-bit FIFO and packs nibble pairs onto a valid/ready byte stream.
// Macro PARITY_CHECK_EN enables per-byte and sticky even-parity checking of the EDO lane.
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter bit      LO_FIRST   = 1'b1,
  parameter nibble_t PAD_NIBBLE = 4'h0
) (
  input  logic                Clock,
  input  logic                Sclr,
  input  logic                Empty,
  input  logic [NIBBLE_W-1:0] Q,
  input  logic [PARITY_W-1:0] EDO,
  output logic                RdReq,
  input  logic                Flush,
  output logic [BYTE_W-1:0]   Byte,
  output logic                ByteValid,
  input  logic                ByteReady,
  output logic                Partial,
  output logic                ParErr,
  output logic                ParErrSticky
);
  logic       inflight;
  logic       lo_valid;
  nib_par_t   cap_d;
  nib_par_t   held;
  logic [2:0] occ;
  logic       out_free;
  logic       capture_lo;
  logic       capture_pair;
  logic       flush_ok;
  logic       load_byte;
  byte_t      pair_byte;
  byte_t      flush_byte;

  // Reads are throttled on registered state only, so ByteReady never reaches RdReq.
  assign occ          = 3'({ByteValid, 1'b0}) + 3'(lo_valid) + 3'(inflight);
  assign RdReq        = !Sclr && !Empty && (occ < 3'd3);
  assign out_free     = !ByteValid || ByteReady;
  assign capture_lo   = inflight && !lo_valid;
  assign capture_pair = inflight && lo_valid;
  assign flush_ok     = Flush && lo_valid && !inflight && Empty && out_free;
  assign load_byte    = capture_pair || flush_ok;
  assign pair_byte    = LO_FIRST ? {Q, held.data} : {held.data, Q};
  assign flush_byte   = LO_FIRST ? {PAD_NIBBLE, held.data} : {held.data, PAD_NIBBLE};

  nibble_capture_reg u_cap (
    .Clock    (Clock),
    .Sclr     (Sclr),
    .load     (capture_lo),
    .clear    (load_byte),
    .d        (cap_d),
    .q        (held),
    .lo_valid (lo_valid)
  );

  always_ff @(posedge Clock) begin
    if (Sclr) inflight <= 1'b0;
    else      inflight <= RdReq;
  end

  always_ff @(posedge Clock) begin
    if (Sclr) begin
      Byte      <= '0;
      ByteValid <= 1'b0;
      Partial   <= 1'b0;
    end else if (load_byte) begin
      Byte      <= capture_pair ? pair_byte : flush_byte;
      ByteValid <= 1'b1;
      Partial   <= flush_ok;
    end else if (ByteReady) begin
      ByteValid <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  assign cap_d = '{par: EDO, data: Q};

  always_ff @(posedge Clock) begin
    if (Sclr) begin
      ParErr       <= 1'b0;
      ParErrSticky <= 1'b0;
    end else begin
      if (load_byte)
        ParErr <= even_par(held.data, held.par) || (capture_pair && even_par(Q, EDO));
      if (ByteValid && ByteReady && ParErr)
        ParErrSticky <= 1'b1;
    end
  end
`else
  logic unused_par;
  assign cap_d        = '{par: '0, data: Q};
  assign unused_par   = ^{EDO, held.par};
  assign ParErr       = 1'b0;
  assign ParErrSticky = 1'b0;
`endif

  // A second nibble must never land on an occupied, stalled output register.
  a_no_overflow: assert property (@(posedge Clock) disable iff (Sclr) !(capture_pair && !out_free));
endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: queue-based FIFO model feeding two parameterisations of the packer.
module tb_fifo_nibble_packer;
`ifdef PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       part;
    logic       perr;
  } obs_t;

  logic       Clock, Sclr, Empty, Flush, ByteReady, EDO;
  logic [3:0] Q;
  logic       RdReq, ByteValid, Partial, ParErr, ParErrSticky;
  logic [7:0] Byte;
  logic       RdReq1, ByteValid1, Partial1, ParErr1, ParErrSticky1;
  logic [7:0] Byte1;

  int         n_tests, n_fail;
  int         cyc, rd_cnt, first_rd, rd_diff, stab_err, underflow;
  logic       stalled, hold_part, hold_perr;
  logic [7:0] hold_byte;
  logic [4:0] fifo_q[$];
  obs_t       obs_q[$];

  fifo_nibble_packer dut0 (
    .Clock(Clock), .Sclr(Sclr), .Empty(Empty), .Q(Q), .EDO(EDO), .RdReq(RdReq),
    .Flush(Flush), .Byte(Byte), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .Partial(Partial), .ParErr(ParErr), .ParErrSticky(ParErrSticky)
  );

  fifo_nibble_packer #(.LO_FIRST(1'b0), .PAD_NIBBLE(4'h5)) dut1 (
    .Clock(Clock), .Sclr(Sclr), .Empty(Empty), .Q(Q), .EDO(EDO), .RdReq(RdReq1),
    .Flush(Flush), .Byte(Byte1), .ByteValid(ByteValid1), .ByteReady(ByteReady),
    .Partial(Partial1), .ParErr(ParErr1), .ParErrSticky(ParErrSticky1)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // One clock: observe at negedge, then model the FIFO read port just after posedge.
  task automatic tick();
    logic rd;
    obs_t o;
    @(negedge Clock);
    rd = RdReq;
    if (RdReq !== RdReq1 || ByteValid !== ByteValid1 || Partial !== Partial1 ||
        ParErr !== ParErr1 || ParErrSticky !== ParErrSticky1)
      rd_diff++;
    if (stalled && (ByteValid !== 1'b1 || Byte !== hold_byte || Partial !== hold_part ||
                    ParErr !== hold_perr))
      stab_err++;
    stalled   = ByteValid && !ByteReady;
    hold_byte = Byte;
    hold_part = Partial;
    hold_perr = ParErr;
    if (ByteValid && ByteReady) begin
      o.cyc = cyc; o.b0 = Byte; o.b1 = Byte1; o.part = Partial; o.perr = ParErr;
      obs_q.push_back(o);
    end
    if (rd) begin
      rd_cnt++;
      if (first_rd < 0) first_rd = cyc;
    end
    @(posedge Clock);
    cyc++;
    #1;
    if (rd) begin
      if (fifo_q.size() != 0) {EDO, Q} = fifo_q.pop_front();
      else underflow++;
    end
    Empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [3:0] n, input logic bad);
    fifo_q.push_back({(^n) ^ bad, n});
  endtask

  task automatic clear_stats();
    rd_cnt = 0; first_rd = -1; rd_diff = 0; stab_err = 0; underflow = 0;
    stalled = 1'b0;
    obs_q.delete();
  endtask

  task automatic do_reset();
    Sclr = 1'b1; Flush = 1'b0;
    fifo_q.delete();
    tick(); tick();
    Sclr = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_tests++; if (RdReq !== 1'b0) begin n_fail++; $display("FAIL rst_rdreq: got %b exp 0", RdReq); end
    n_tests++; if (ByteValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", ByteValid); end
    n_tests++; if (Byte !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %h exp 00", Byte); end
    n_tests++; if (Partial !== 1'b0) begin n_fail++; $display("FAIL rst_partial: got %b exp 0", Partial); end
    n_tests++; if (ParErr !== 1'b0) begin n_fail++; $display("FAIL rst_parerr: got %b exp 0", ParErr); end
    n_tests++; if (ParErrSticky !== 1'b0) begin n_fail++; $display("FAIL rst_sticky: got %b exp 0", ParErrSticky); end
    Sclr = 1'b0;
    clear_stats();
  endtask

  task automatic test_stream();
    logic [3:0] d [6];
    logic [7:0] e0, e1;
    d = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    do_reset();
    ByteReady = 1'b1;
    for (int i = 0; i < 6; i++) push(d[i], 1'b0);
    for (int c = 0; c < 60 && obs_q.size() < 3; c++) tick();
    tick(); tick();
    n_tests++; if (obs_q.size() != 3) begin n_fail++; $display("FAIL stream_count: got %0d exp 3", obs_q.size()); end
    for (int k = 0; k < 3 && k < obs_q.size(); k++) begin
      e0 = {d[2*k+1], d[2*k]};
      e1 = {d[2*k], d[2*k+1]};
      n_tests++; if (obs_q[k].b0 !== e0) begin n_fail++; $display("FAIL stream_lofirst[%0d]: got %h exp %h", k, obs_q[k].b0, e0); end
      n_tests++; if (obs_q[k].b1 !== e1) begin n_fail++; $display("FAIL stream_hifirst[%0d]: got %h exp %h", k, obs_q[k].b1, e1); end
      n_tests++; if (obs_q[k].part !== 1'b0) begin n_fail++; $display("FAIL stream_partial[%0d]: got %b exp 0", k, obs_q[k].part); end
    end
    if (obs_q.size() > 0) begin
      n_tests++; if (obs_q[0].cyc - first_rd != 3) begin n_fail++; $display("FAIL stream_latency: got %0d exp 3", obs_q[0].cyc - first_rd); end
    end
    n_tests++; if (rd_cnt != 6) begin n_fail++; $display("FAIL stream_reads: got %0d exp 6", rd_cnt); end
    n_tests++; if (rd_diff != 0 || underflow != 0) begin n_fail++; $display("FAIL stream_consistency: got %0d/%0d exp 0/0", rd_diff, underflow); end
  endtask

  task automatic test_stall();
    do_reset();
    ByteReady = 1'b0;
    push(4'hA, 1'b0); push(4'hB, 1'b0); push(4'hC, 1'b0); push(4'hD, 1'b0); push(4'hE, 1'b0);
    repeat (10) tick();
    n_tests++; if (rd_cnt != 3) begin n_fail++; $display("FAIL stall_reads: got %0d exp 3", rd_cnt); end
    n_tests++; if (RdReq !== 1'b0) begin n_fail++; $display("FAIL stall_rdreq: got %b exp 0", RdReq); end
    n_tests++; if (ByteValid !== 1'b1 || Byte !== 8'hBA) begin n_fail++; $display("FAIL stall_hold: got %b/%h exp 1/ba", ByteValid, Byte); end
    n_tests++; if (Byte1 !== 8'hAB) begin n_fail++; $display("FAIL stall_hold_hifirst: got %h exp ab", Byte1); end
    n_tests++; if (dut0.lo_valid !== 1'b1) begin n_fail++; $display("FAIL stall_lo_valid: got %b exp 1", dut0.lo_valid); end
    n_tests++; if (obs_q.size() != 0 || stab_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d/%0d exp 0/0", obs_q.size(), stab_err); end
    ByteReady = 1'b1;
    for (int c = 0; c < 20 && obs_q.size() < 2; c++) tick();
    repeat (3) tick();
    n_tests++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL stall_count: got %0d exp 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_tests++; if (obs_q[0].b0 !== 8'hBA) begin n_fail++; $display("FAIL stall_first: got %h exp ba", obs_q[0].b0); end
      n_tests++; if (obs_q[1].b0 !== 8'hDC || obs_q[1].b1 !== 8'hCD) begin n_fail++; $display("FAIL stall_second: got %h/%h exp dc/cd", obs_q[1].b0, obs_q[1].b1); end
    end
    n_tests++; if (rd_cnt != 5 || dut0.lo_valid !== 1'b1 || ByteValid !== 1'b0) begin n_fail++; $display("FAIL stall_tail: got %0d/%b/%b exp 5/1/0", rd_cnt, dut0.lo_valid, ByteValid); end
  endtask

  task automatic test_flush();
    do_reset();
    ByteReady = 1'b0;
    push(4'h7, 1'b0);
    for (int c = 0; c < 10 && rd_cnt < 1; c++) tick();
    Flush = 1'b1; tick(); Flush = 1'b0;
    n_tests++; if (ByteValid !== 1'b0 || dut0.lo_valid !== 1'b1) begin n_fail++; $display("FAIL flush_inflight: got %b/%b exp 0/1", ByteValid, dut0.lo_valid); end
    tick();
    Flush = 1'b1; tick(); Flush = 1'b0;
    n_tests++; if (ByteValid !== 1'b1 || Byte !== 8'h07 || Partial !== 1'b1) begin n_fail++; $display("FAIL flush_byte: got %b/%h/%b exp 1/07/1", ByteValid, Byte, Partial); end
    n_tests++; if (Byte1 !== 8'h75) begin n_fail++; $display("FAIL flush_hifirst: got %h exp 75", Byte1); end
    repeat (3) tick();
    ByteReady = 1'b1;
    tick(); tick();
    n_tests++; if (obs_q.size() != 1 || ByteValid !== 1'b0 || stab_err != 0) begin n_fail++; $display("FAIL flush_drain: got %0d/%b/%0d exp 1/0/0", obs_q.size(), ByteValid, stab_err); end
    push(4'h1, 1'b0); push(4'h2, 1'b0);
    for (int c = 0; c < 10 && rd_cnt < 3; c++) tick();
    Flush = 1'b1; tick(); Flush = 1'b0;
    n_tests++; if (ByteValid !== 1'b1 || Byte !== 8'h21 || Partial !== 1'b0) begin n_fail++; $display("FAIL flush_ignored_pair: got %b/%h/%b exp 1/21/0", ByteValid, Byte, Partial); end
  endtask

  task automatic test_parity();
    logic [3:0] d [6];
    logic       b [6];
    d = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
    b = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    ByteReady = 1'b1;
    for (int i = 0; i < 4; i++) push(d[i], b[i]);
    for (int c = 0; c < 40 && obs_q.size() < 2; c++) tick();
    tick(); tick();
    n_tests++; if (obs_q.size() != 2) begin n_fail++; $display("FAIL par_count: got %0d exp 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      n_tests++; if (obs_q[0].b0 !== 8'h43 || obs_q[0].perr !== PAR_EN) begin n_fail++; $display("FAIL par_bad_byte: got %h/%b exp 43/%b", obs_q[0].b0, obs_q[0].perr, PAR_EN); end
      n_tests++; if (obs_q[1].perr !== 1'b0) begin n_fail++; $display("FAIL par_clean_byte: got %b exp 0", obs_q[1].perr); end
    end
    n_tests++; if (ParErrSticky !== PAR_EN) begin n_fail++; $display("FAIL par_sticky: got %b exp %b", ParErrSticky, PAR_EN); end
    for (int i = 4; i < 6; i++) push(d[i], b[i]);
    for (int c = 0; c < 40 && obs_q.size() < 3; c++) tick();
    tick(); tick();
    n_tests++; if (obs_q.size() != 3 || ParErrSticky !== PAR_EN) begin n_fail++; $display("FAIL par_sticky_hold: got %0d/%b exp 3/%b", obs_q.size(), ParErrSticky, PAR_EN); end
    do_reset();
    n_tests++; if (ParErrSticky !== 1'b0 || ParErr !== 1'b0) begin n_fail++; $display("FAIL par_sclr: got %b/%b exp 0/0", ParErrSticky, ParErr); end
  endtask

  task automatic test_sclr_midflight();
    do_reset();
    ByteReady = 1'b0;
    for (int i = 1; i <= 8; i++) push(4'(i), 1'b0);
    for (int c = 0; c < 20 && rd_cnt < 3; c++) tick();
    n_tests++; if (ByteValid !== 1'b1) begin n_fail++; $display("FAIL sclr_pre_valid: got %b exp 1", ByteValid); end
    Sclr = 1'b1;
    fifo_q.delete();
    tick();
    n_tests++; if (RdReq !== 1'b0 || ByteValid !== 1'b0 || Byte !== 8'h00 || Partial !== 1'b0 || ParErr !== 1'b0) begin
      n_fail++; $display("FAIL sclr_outputs: got %b/%b/%h/%b/%b exp 0/0/00/0/0", RdReq, ByteValid, Byte, Partial, ParErr);
    end
    n_tests++; if (dut0.lo_valid !== 1'b0) begin n_fail++; $display("FAIL sclr_lo_valid: got %b exp 0", dut0.lo_valid); end
    Sclr = 1'b0;
    clear_stats();
    ByteReady = 1'b1;
    push(4'h9, 1'b0); push(4'hA, 1'b0);
    for (int c = 0; c < 20 && obs_q.size() < 1; c++) tick();
    tick(); tick();
    n_tests++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL sclr_fresh_count: got %0d exp 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      n_tests++; if (obs_q[0].b0 !== 8'hA9 || obs_q[0].b1 !== 8'h9A || obs_q[0].part !== 1'b0) begin
        n_fail++; $display("FAIL sclr_fresh_pair: got %h/%h/%b exp a9/9a/0", obs_q[0].b0, obs_q[0].b1, obs_q[0].part);
      end
    end
  endtask

  task automatic test_random(input int iter);
    int         n, pushed, nexp;
    logic [3:0] d[$];
    logic       bad[$];
    obs_t       e;
    obs_t       exp_q[$];
    logic       any_bad;
    do_reset();
    n = $urandom_range(21, 40);
    for (int i = 0; i < n; i++) begin
      d.push_back(4'($urandom_range(0, 15)));
      bad.push_back($urandom_range(0, 7) == 0);
    end
    // Reference stream: nibbles pair up in read order; an odd tail leaves as a padded byte.
    any_bad = 1'b0;
    for (int k = 0; 2*k+1 < n; k++) begin
      e.cyc = 0; e.part = 1'b0;
      e.b0 = {d[2*k+1], d[2*k]};
      e.b1 = {d[2*k], d[2*k+1]};
      e.perr = PAR_EN & (bad[2*k] | bad[2*k+1]);
      any_bad |= e.perr;
      exp_q.push_back(e);
    end
    if (n % 2 == 1) begin
      e.cyc = 0; e.part = 1'b1;
      e.b0 = {4'h0, d[n-1]};
      e.b1 = {d[n-1], 4'h5};
      e.perr = PAR_EN & bad[n-1];
      any_bad |= e.perr;
      exp_q.push_back(e);
    end
    nexp = exp_q.size();
    pushed = 0;
    for (int c = 0; c < 3000 && rd_cnt < n; c++) begin
      if (pushed < n && $urandom_range(0, 1) == 1) begin
        push(d[pushed], bad[pushed]);
        pushed++;
      end
      ByteReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    ByteReady = 1'b1;
    repeat (6) tick();
    Flush = 1'b1; tick(); Flush = 1'b0;
    repeat (4) tick();
    n_tests++; if (rd_cnt != n) begin n_fail++; $display("FAIL rnd%0d_reads: got %0d exp %0d", iter, rd_cnt, n); end
    n_tests++; if (obs_q.size() != nexp) begin n_fail++; $display("FAIL rnd%0d_count: got %0d exp %0d", iter, obs_q.size(), nexp); end
    for (int k = 0; k < nexp && k < obs_q.size(); k++) begin
      n_tests++;
      if (obs_q[k].b0 !== exp_q[k].b0 || obs_q[k].b1 !== exp_q[k].b1 ||
          obs_q[k].part !== exp_q[k].part || obs_q[k].perr !== exp_q[k].perr) begin
        n_fail++;
        $display("FAIL rnd%0d_byte[%0d]: got %h/%h/%b/%b exp %h/%h/%b/%b", iter, k,
                 obs_q[k].b0, obs_q[k].b1, obs_q[k].part, obs_q[k].perr,
                 exp_q[k].b0, exp_q[k].b1, exp_q[k].part, exp_q[k].perr);
      end
    end
    n_tests++; if (ParErrSticky !== any_bad) begin n_fail++; $display("FAIL rnd%0d_sticky: got %b exp %b", iter, ParErrSticky, any_bad); end
    n_tests++; if (stab_err != 0 || rd_diff != 0 || underflow != 0) begin
      n_fail++; $display("FAIL rnd%0d_protocol: got %0d/%0d/%0d exp 0/0/0", iter, stab_err, rd_diff, underflow);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    Sclr = 1'b1; Empty = 1'b1; Flush = 1'b0; ByteReady = 1'b0; Q = 4'h0; EDO = 1'b0;
    clear_stats();
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_parity();
    test_sclr_midflight();
    for (int i = 0; i < 4; i++) test_random(i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
